// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: requester side of the instruction-memory read port.
// Holds the PC, reads the combinational instruction memory, latches the
// word into IR and offers it to decode over a valid/ack handshake. A taken
// jz from decode redirects the PC by a signed 8-bit word offset.
// Optional feature macro: PREFETCH_EN (one-entry prefetch buffer that
// gives a 1-cycle ack-to-next-valid turnaround on sequential code).

module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    MEM_DEPTH  = 128,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [15:0]           Instruction,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  I_rd,
  output logic [15:0]           IR,
  output logic                  Instr_valid,
  input  logic                  Instr_ack,
  input  logic                  Branch_taken,
  input  logic [7:0]            Branch_offset,
  output logic                  Halt
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

  // MEM_DEPTH widened by one bit so PC+1 can be compared without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_seq;
  logic [ADDR_WIDTH-1:0]   pc_branch;
  logic [ADDR_WIDTH-1:0]   offset_ext;
  logic                    pc_in_range;
  logic                    ack_valid;

  assign pc_in_range = ({1'b0, pc} < DEPTH_W);
  assign pc_seq      = pc + ONE;
  assign offset_ext  = {{(ADDR_WIDTH-8){Branch_offset[7]}}, Branch_offset};
  assign pc_branch   = pc + offset_ext;
  assign ack_valid   = (state == VALID) && Instr_ack;

`ifdef PREFETCH_EN
  logic [15:0]           pb;
  logic                  pb_valid;
  logic [ADDR_WIDTH:0]   pc_seq_wide;
  logic                  seq_in_range;
  logic                  pb_req;
  logic                  pb_use;

  assign pc_seq_wide  = {1'b0, pc} + {1'b0, ONE};
  assign seq_in_range = (pc_seq_wide < DEPTH_W);
  assign pb_req       = (state == VALID) && !pb_valid && seq_in_range;
  assign pb_use       = ack_valid && !Branch_taken && pb_valid;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (Start) next_state = FETCH;
      FETCH: next_state = pc_in_range ? VALID : HALT;
      VALID: begin
        if (ack_valid) begin
`ifdef PREFETCH_EN
          next_state = pb_use ? VALID : FETCH;
`else
          next_state = FETCH;
`endif
        end
      end
      HALT:  if (Start) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Memory-side outputs; Address is parked at zero whenever no read is issued.
  always_comb begin
    I_rd    = 1'b0;
    Address = '0;
    Halt    = (state == HALT);
    case (state)
      FETCH: begin
        if (pc_in_range) begin
          I_rd    = 1'b1;
          Address = pc;
        end
      end
`ifdef PREFETCH_EN
      VALID: begin
        if (pb_req) begin
          I_rd    = 1'b1;
          Address = pc_seq;
        end
      end
`endif
      default: begin
        I_rd    = 1'b0;
        Address = '0;
      end
    endcase
  end

  // PC, IR and handshake bookkeeping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc          <= PC_RESET;
      IR          <= 16'h0000;
      Instr_valid <= 1'b0;
`ifdef PREFETCH_EN
      pb          <= 16'h0000;
      pb_valid    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) begin
            pc <= PC_RESET;
`ifdef PREFETCH_EN
            pb_valid <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (pc_in_range) begin
            IR          <= Instruction;
            Instr_valid <= 1'b1;
          end
        end
        VALID: begin
`ifdef PREFETCH_EN
          if (pb_req && !Instr_ack) begin
            pb       <= Instruction;
            pb_valid <= 1'b1;
          end
`endif
          if (Instr_ack) begin
            if (Branch_taken) begin
              pc          <= pc_branch;
              Instr_valid <= 1'b0;
`ifdef PREFETCH_EN
              pb_valid    <= 1'b0;
`endif
            end else begin
              pc <= pc_seq;
`ifdef PREFETCH_EN
              if (pb_valid) begin
                IR       <= pb;
                pb_valid <= 1'b0;
              end else begin
                Instr_valid <= 1'b0;
              end
`else
              Instr_valid <= 1'b0;
`endif
            end
          end
        end
        default: begin
          Instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit (default
// build). A behavioural model tracks the expected PC with plain integer
// arithmetic and reads expected instructions straight from the memory array.

module tb_instr_fetch_unit;

  localparam int DEPTH = 128;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Instr_ack = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [7:0]  Branch_offset = 8'h00;
  logic [15:0] Instruction;
  logic [15:0] Address;
  logic        I_rd;
  logic [15:0] IR;
  logic        Instr_valid;
  logic        Halt;

  logic [15:0] mem [0:DEPTH-1];

  int checks = 0;
  int failures = 0;
  int bad_reads = 0;
  int m_pc = 0;

  instr_fetch_unit dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Start         (Start),
    .Instruction   (Instruction),
    .Address       (Address),
    .I_rd          (I_rd),
    .IR            (IR),
    .Instr_valid   (Instr_valid),
    .Instr_ack     (Instr_ack),
    .Branch_taken  (Branch_taken),
    .Branch_offset (Branch_offset),
    .Halt          (Halt)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Combinational instruction memory; out-of-range reads return a marker.
  assign Instruction = (Address < 16'(DEPTH)) ? mem[Address[6:0]] : 16'hDEAD;

  // Any read strobe at an out-of-range address is recorded.
  always @(negedge Clk) begin
    if (I_rd && (Address >= 16'(DEPTH))) bad_reads++;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic hard_reset;
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    m_pc = 0;
  endtask

  // Called in the cycle after Start/ack: checks the fetch (or halt) and the
  // instruction that should then be presented.
  task automatic check_fetch(input string name);
    if (m_pc < DEPTH) begin
      checks++;
      if (I_rd !== 1'b1 || Address !== 16'(m_pc))
        $display("[TB] FAIL %s_fetch: got I_rd=%0b Address=%0d, expected I_rd=1 Address=%0d",
                 name, I_rd, Address, m_pc);
      if (I_rd !== 1'b1 || Address !== 16'(m_pc)) failures++;
      tick();
      checks++;
      if (Instr_valid !== 1'b1 || IR !== mem[m_pc] || I_rd !== 1'b0 || Halt !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_valid: got valid=%0b IR=%h I_rd=%0b Halt=%0b, expected valid=1 IR=%h I_rd=0 Halt=0",
                 name, Instr_valid, IR, I_rd, Halt, mem[m_pc]);
      end
    end else begin
      checks++;
      if (I_rd !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_noread: got I_rd=%0b Address=%h, expected I_rd=0", name, I_rd, Address);
      end
      tick();
      checks++;
      if (Halt !== 1'b1 || Instr_valid !== 1'b0 || I_rd !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_halt: got Halt=%0b valid=%0b I_rd=%0b, expected Halt=1 valid=0 I_rd=0",
                 name, Halt, Instr_valid, I_rd);
      end
    end
  endtask

  // Acknowledge the current instruction, update the model PC, check the refetch.
  task automatic do_ack(input bit br, input logic [7:0] off, input string name);
    Instr_ack     = 1'b1;
    Branch_taken  = br;
    Branch_offset = off;
    tick();
    Instr_ack     = 1'b0;
    Branch_taken  = 1'b0;
    Branch_offset = 8'($urandom);
    if (br) m_pc = (m_pc + int'($signed(off))) & 32'h0000FFFF;
    else    m_pc = (m_pc + 1) & 32'h0000FFFF;
    checks++;
    if (Instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_ackclear: got valid=%0b, expected 0", name, Instr_valid);
    end
    check_fetch(name);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({Address, I_rd, IR, Instr_valid, Halt} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL %s: got Address=%h I_rd=%0b IR=%h valid=%0b Halt=%0b, expected all zero",
               name, Address, I_rd, IR, Instr_valid, Halt);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    Rst_n = 1'b1;
    Instr_ack = 1'b1;
    Branch_taken = 1'b1;
    repeat (3) tick();
    Instr_ack = 1'b0;
    Branch_taken = 1'b0;
    check_all_zero("idle_ack_ignored");
  endtask

  task automatic test_start_stall;
    mem[0] = 16'h301E;
    do_start();
    check_fetch("start");
    for (int i = 0; i < 10; i++) begin
      if (i == 5) Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++;
      if (Instr_valid !== 1'b1 || IR !== 16'h301E || I_rd !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_%0d: got valid=%0b IR=%h I_rd=%0b, expected valid=1 IR=301e I_rd=0",
                 i, Instr_valid, IR, I_rd);
      end
    end
  endtask

  task automatic test_sequential;
    hard_reset();
    mem[0] = 16'h301E;
    mem[1] = 16'h3101;
    mem[2] = 16'h2110;
    mem[3] = 16'h2401;
    do_start();
    check_fetch("seq0");
    for (int i = 1; i < 4; i++) do_ack(1'b0, 8'h00, $sformatf("seq%0d", i));
  endtask

  task automatic test_branch;
    hard_reset();
    do_start();
    check_fetch("br_start");
    do_ack(1'b1, 8'h09, "br_to9");
    do_ack(1'b1, 8'h02, "br_plus2");
    do_ack(1'b1, 8'h01, "br_to12");
    do_ack(1'b1, 8'hFC, "br_minus4");
    do_ack(1'b1, 8'h00, "br_zero");
  endtask

  task automatic test_boundary;
    hard_reset();
    bad_reads = 0;
    do_start();
    check_fetch("bd_start");
    do_ack(1'b1, 8'h7F, "bd_to127");
    do_ack(1'b0, 8'h00, "bd_past_end");
    Instr_ack = 1'b1;
    Branch_taken = 1'b1;
    repeat (2) tick();
    Instr_ack = 1'b0;
    Branch_taken = 1'b0;
    checks++;
    if (Halt !== 1'b1 || I_rd !== 1'b0 || bad_reads != 0) begin
      failures++;
      $display("[TB] FAIL halt_hold: got Halt=%0b I_rd=%0b bad_reads=%0d, expected Halt=1 I_rd=0 bad_reads=0",
               Halt, I_rd, bad_reads);
    end
    do_start();
    check_fetch("bd_restart");
    do_ack(1'b1, 8'hFF, "bd_negwrap");
  endtask

  task automatic test_reset_midop;
    hard_reset();
    do_start();
    Rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_fetch");
    #1;
    Rst_n = 1'b1;
    tick();
    do_start();
    check_fetch("rst_fetch_restart");
    Rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_valid");
    #1;
    Rst_n = 1'b1;
    tick();
    do_start();
    check_fetch("rst_valid_restart");
  endtask

  task automatic test_random;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    hard_reset();
    do_start();
    check_fetch("rnd_start");
    for (int n = 0; n < 60; n++) begin
      if (m_pc >= DEPTH) begin
        do_start();
        check_fetch("rnd_restart");
      end else begin
        int stall_cycles;
        stall_cycles = $urandom_range(0, 2);
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          checks++;
          if (Instr_valid !== 1'b1 || IR !== mem[m_pc]) begin
            failures++;
            $display("[TB] FAIL rnd_stall: got valid=%0b IR=%h, expected valid=1 IR=%h",
                     Instr_valid, IR, mem[m_pc]);
          end
        end
        do_ack($urandom_range(0, 3) == 0, 8'($urandom), "rnd_ack");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 16'h0101 + 16'h1000);
    test_reset();
    test_start_stall();
    test_sequential();
    test_branch();
    test_boundary();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
